instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/FETCH/HOLD sequencer with PC, IR and redirect handling.
// Optional FETCH_TIMEOUT_EN macro adds a mem_ack wait limit with a fetch_err pulse and retry.
module instr_fetch #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [63:0] pc,
  output logic [63:0] pcplus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [63:0] ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             fetch_err_q, fetch_err_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef FETCH_TIMEOUT_EN
    // The counter falls back to zero whenever FETCH is not continuing to wait.
    wait_cnt_d  = '0;
    fetch_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) pc_d = redirect_pc & ALIGN_MASK;
      end
      FETCH: begin
        if (redirect) begin
          pc_d    = redirect_pc & ALIGN_MASK;
          state_d = IDLE;
        end else if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = HOLD;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          if (wait_cnt_q == CNT_LAST) begin
            fetch_err_d = 1'b1;
            state_d     = IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc & ALIGN_MASK;
          state_d = IDLE;
        end else if (instr_ready) begin
          pc_d    = pc_q + 64'd4;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign mem_req     = (state_q == FETCH);
  assign mem_addr    = pc_q & ALIGN_MASK;
  assign instr_valid = (state_q == HOLD);
  assign instr       = ir_q;
  assign op          = ir_q[31:26];
  assign funct       = ir_q[5:0];
  assign pc          = pc_q;
  assign pcplus4     = pc_q + 64'd4;

endmodule
